// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for the non-forwarding 5-stage pipeline: one countdown per
// architectural register, decoded sources are checked against it before issue.
module hazard_scoreboard #(
   parameter int unsigned PIPE_DIST = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic        id_uses_rs1_i,
   input  logic        id_uses_rs2_i,
   input  logic [4:0]  id_rd_addr_i,
   input  logic        id_rd_wren_i,
   input  logic        flush_i,
   input  logic        ext_stall_i,
   output logic        stall_o,
   output logic        issue_o,
   output logic [31:0] pending_o
);

   localparam logic [1:0] CntLoad = 2'(PIPE_DIST - 1);

   logic [1:0] cnt_q [31:1];
   logic [1:0] cnt_d [31:1];
   logic [1:0] cnt_view [32];
   logic       haz1, haz2;

   // x0 is never tracked, so its view entry is tied to zero.
   always_comb begin
      cnt_view[0] = '0;
      for (int r = 1; r < 32; r++) begin
         cnt_view[r] = cnt_q[r];
      end
   end

   assign haz1 = id_uses_rs1_i & (id_rs1_addr_i != 5'd0) & (cnt_view[id_rs1_addr_i] != 2'd0);
   assign haz2 = id_uses_rs2_i & (id_rs2_addr_i != 5'd0) & (cnt_view[id_rs2_addr_i] != 2'd0);

   // Handshake: stall_o and issue_o are same-cycle decisions on the ID instruction;
   // issue_o=1 means it leaves ID at this rising edge, stall_o=1 means it stays put.
   assign stall_o = id_valid_i & ~flush_i & (haz1 | haz2);
   assign issue_o = id_valid_i & ~flush_i & ~ext_stall_i & ~stall_o;

   always_comb begin
      for (int r = 1; r < 32; r++) begin
         cnt_d[r] = cnt_q[r];
         if (!ext_stall_i) begin
            if (issue_o && id_rd_wren_i && (id_rd_addr_i == 5'(r))) begin
               cnt_d[r] = CntLoad;
            end else if (cnt_q[r] != 2'd0) begin
               cnt_d[r] = cnt_q[r] - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 1; r < 32; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int r = 1; r < 32; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   always_comb begin
      pending_o = '0;
      for (int r = 1; r < 32; r++) begin
         pending_o[r] = (cnt_q[r] != 2'd0);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed dependency scenarios plus random traffic
// checked against a virtual-time model of when each destination becomes readable.
module tb_hazard_scoreboard;

   localparam int PIPE_DIST = 3;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        id_valid_i = 1'b0;
   logic [4:0]  id_rs1_addr_i = '0;
   logic [4:0]  id_rs2_addr_i = '0;
   logic        id_uses_rs1_i = 1'b0;
   logic        id_uses_rs2_i = 1'b0;
   logic [4:0]  id_rd_addr_i = '0;
   logic        id_rd_wren_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        ext_stall_i = 1'b0;
   logic        stall_o;
   logic        issue_o;
   logic [31:0] pending_o;

   int total = 0;
   int bad = 0;
   logic [33:0] exp_q[$];

   hazard_scoreboard #(.PIPE_DIST(PIPE_DIST)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .id_valid_i    (id_valid_i),
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_uses_rs1_i (id_uses_rs1_i),
      .id_uses_rs2_i (id_uses_rs2_i),
      .id_rd_addr_i  (id_rd_addr_i),
      .id_rd_wren_i  (id_rd_wren_i),
      .flush_i       (flush_i),
      .ext_stall_i   (ext_stall_i),
      .stall_o       (stall_o),
      .issue_o       (issue_o),
      .pending_o     (pending_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   // Reference model: a virtual clock that only advances on unfrozen cycles; a register
   // is readable once virtual time reaches its producer's issue time plus PIPE_DIST.
   int vtime = 0;
   int ready_v [32];

   function automatic int m_remaining(input logic [4:0] r);
      if (r == 5'd0) return 0;
      return (ready_v[r] > vtime) ? ready_v[r] - vtime : 0;
   endfunction

   function automatic bit m_stall();
      bit h1, h2;
      h1 = id_uses_rs1_i && (m_remaining(id_rs1_addr_i) > 0);
      h2 = id_uses_rs2_i && (m_remaining(id_rs2_addr_i) > 0);
      return id_valid_i && !flush_i && (h1 || h2);
   endfunction

   function automatic bit m_issue();
      return id_valid_i && !flush_i && !ext_stall_i && !m_stall();
   endfunction

   function automatic logic [31:0] m_pending();
      logic [31:0] p;
      p = '0;
      for (int r = 0; r < 32; r++) p[r] = (m_remaining(5'(r)) > 0);
      return p;
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vtime <= 0;
         for (int r = 0; r < 32; r++) ready_v[r] <= 0;
      end else if (!ext_stall_i) begin
         if (m_issue() && id_rd_wren_i && id_rd_addr_i != 5'd0)
            ready_v[id_rd_addr_i] <= vtime + PIPE_DIST;
         vtime <= vtime + 1;
      end
   end

   // driver tasks
   task automatic apply(input bit v, input logic [4:0] a1, input logic [4:0] a2,
                        input bit u1, input bit u2, input logic [4:0] rd,
                        input bit wr, input bit fl, input bit ex);
      @(negedge clk_i);
      id_valid_i    = v;
      id_rs1_addr_i = a1;
      id_rs2_addr_i = a2;
      id_uses_rs1_i = u1;
      id_uses_rs2_i = u2;
      id_rd_addr_i  = rd;
      id_rd_wren_i  = wr;
      flush_i       = fl;
      ext_stall_i   = ex;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      #1;
      total++; if (pending_o !== 32'h0) begin bad++; $display("FAIL rst_pending: got %h want %h", pending_o, 32'h0); end
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall_o); end
      total++; if (issue_o !== 1'b0) begin bad++; $display("FAIL rst_issue: got %b want 0", issue_o); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      apply(1, 0, 0, 0, 0, 5'd10, 1, 0, 0);
      total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL rst_prod_issue: got %b want 1", issue_o); end
      idle(1);
      total++; if (pending_o[10] !== 1'b1) begin bad++; $display("FAIL rst_prod_pending: got %b want 1", pending_o[10]); end
      #2 rst_ni = 1'b0;
      #1;
      total++; if (pending_o !== 32'h0) begin bad++; $display("FAIL rst_mid_pending: got %h want %h", pending_o, 32'h0); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      apply(1, 5'd10, 0, 1, 0, 0, 0, 0, 0);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_after_stall: got %b want 0", stall_o); end
      total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL rst_after_issue: got %b want 1", issue_o); end
      idle(4);
   endtask

   task automatic test_back_to_back();
      apply(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
      total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL b2b_prod_issue: got %b want 1", issue_o); end
      for (int k = 1; k <= 3; k++) begin
         apply(1, 5'd5, 0, 1, 0, 5'd1, 0, 0, 0);
         total++; if (stall_o !== (k < 3)) begin bad++; $display("FAIL b2b_stall_t%0d: got %b want %b", k, stall_o, (k < 3)); end
         total++; if (issue_o !== (k == 3)) begin bad++; $display("FAIL b2b_issue_t%0d: got %b want %b", k, issue_o, (k == 3)); end
         total++; if (pending_o[5] !== (k < 3)) begin bad++; $display("FAIL b2b_pend_t%0d: got %b want %b", k, pending_o[5], (k < 3)); end
      end
      idle(4);
   endtask

   task automatic test_distance();
      apply(1, 0, 0, 0, 0, 5'd7, 1, 0, 0);
      idle(1);
      apply(1, 0, 5'd7, 0, 1, 0, 0, 0, 0);
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL dist2_stall: got %b want 1", stall_o); end
      apply(1, 0, 5'd7, 0, 1, 0, 0, 0, 0);
      total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL dist2_issue: got %b want 1", issue_o); end
      idle(4);
      apply(1, 0, 0, 0, 0, 5'd7, 1, 0, 0);
      idle(2);
      apply(1, 0, 5'd7, 0, 1, 0, 0, 0, 0);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL dist3_stall: got %b want 0", stall_o); end
      total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL dist3_issue: got %b want 1", issue_o); end
      idle(4);
   endtask

   task automatic test_x0_unused_self();
      apply(1, 0, 0, 0, 0, 5'd0, 1, 0, 0);
      apply(1, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL x0_stall: got %b want 0", stall_o); end
      total++; if (pending_o !== 32'h0) begin bad++; $display("FAIL x0_pending: got %h want %h", pending_o, 32'h0); end
      apply(1, 0, 0, 0, 0, 5'd9, 1, 0, 0);
      apply(1, 5'd1, 5'd9, 1, 0, 0, 0, 0, 0);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL unused_rs2_stall: got %b want 0", stall_o); end
      total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL unused_rs2_issue: got %b want 1", issue_o); end
      idle(4);
      apply(1, 5'd3, 0, 1, 0, 5'd3, 1, 0, 0);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL self_stall: got %b want 0", stall_o); end
      total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL self_issue: got %b want 1", issue_o); end
      idle(1);
      total++; if (pending_o !== 32'h8) begin bad++; $display("FAIL self_pending: got %h want %h", pending_o, 32'h8); end
      idle(4);
   endtask

   task automatic test_flush_ext();
      apply(1, 0, 0, 0, 0, 5'd4, 1, 1, 0);
      total++; if (issue_o !== 1'b0) begin bad++; $display("FAIL flush_issue: got %b want 0", issue_o); end
      idle(1);
      total++; if (pending_o[4] !== 1'b0) begin bad++; $display("FAIL flush_pending: got %b want 0", pending_o[4]); end
      apply(1, 0, 0, 0, 0, 5'd4, 1, 0, 0);
      apply(1, 5'd4, 0, 1, 0, 0, 0, 0, 1);
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL ext_haz_stall: got %b want 1", stall_o); end
      total++; if (issue_o !== 1'b0) begin bad++; $display("FAIL ext1_issue: got %b want 0", issue_o); end
      apply(1, 5'd1, 0, 1, 0, 5'd2, 1, 0, 1);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL ext2_stall: got %b want 0", stall_o); end
      total++; if (issue_o !== 1'b0) begin bad++; $display("FAIL ext2_issue: got %b want 0", issue_o); end
      apply(1, 5'd4, 0, 1, 0, 0, 0, 1, 0);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_haz_stall: got %b want 0", stall_o); end
      total++; if (pending_o[2] !== 1'b0) begin bad++; $display("FAIL ext_noload: got %b want 0", pending_o[2]); end
      total++; if (pending_o[4] !== 1'b1) begin bad++; $display("FAIL ext_pend_t3: got %b want 1", pending_o[4]); end
      idle(1);
      total++; if (pending_o[4] !== 1'b1) begin bad++; $display("FAIL ext_pend_t4: got %b want 1", pending_o[4]); end
      idle(1);
      total++; if (pending_o[4] !== 1'b0) begin bad++; $display("FAIL ext_pend_t5: got %b want 0", pending_o[4]); end
      idle(3);
   endtask

   task automatic test_waw();
      apply(1, 0, 0, 0, 0, 5'd6, 1, 0, 0);
      apply(1, 0, 0, 0, 0, 5'd6, 1, 0, 0);
      total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL waw_second_issue: got %b want 1", issue_o); end
      for (int k = 2; k <= 4; k++) begin
         apply(1, 5'd6, 0, 1, 0, 0, 0, 0, 0);
         total++; if (issue_o !== (k == 4)) begin bad++; $display("FAIL waw_issue_t%0d: got %b want %b", k, issue_o, (k == 4)); end
      end
      idle(4);
   endtask

   task automatic test_random();
      logic [33:0] exp_w, got_w;
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         exp_q.push_back({m_stall(), m_issue(), m_pending()});
         exp_w = exp_q.pop_front();
         got_w = {stall_o, issue_o, pending_o};
         total++;
         if (got_w !== exp_w) begin
            bad++;
            $display("FAIL rand_cycle%0d: got stall=%b issue=%b pend=%h want stall=%b issue=%b pend=%h",
                     i, got_w[33], got_w[32], got_w[31:0], exp_w[33], exp_w[32], exp_w[31:0]);
         end
      end
      idle(4);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_distance();
      test_x0_unused_self();
      test_flush_ext();
      test_waw();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
